// File: rtl/frequency_capture_sequencer.sv
// Sequences one capture run of the analyzer bank: clear, timed/stopped enable window,
// then reads every result through the external mux into the register file and pulses irq.
module frequency_capture_sequencer #(
    parameter int NUM_VALUES               = 6,
    parameter int CLEAR_CYCLES             = 2,
    parameter int REGISTER_WRITE_OPERATION = 2,
    parameter int REGISTER_IDLE_OPERATION  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] window_length,
    output logic        analyzer_clear,
    output logic        analyzer_enable,
    output logic [7:0]  value_index,
    input  logic [31:0] value_data,
    output logic [1:0]  register_operation,
    output logic [7:0]  register_number,
    output logic [31:0] register_write,
    output logic        busy,
    output logic        irq,
    output logic        timeout,
    output logic [31:0] elapsed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_SELECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [7:0]  LAST_K     = 8'(NUM_VALUES);
    localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_CYCLES - 1);
    localparam logic [1:0]  OP_WRITE   = 2'(REGISTER_WRITE_OPERATION);
    localparam logic [1:0]  OP_IDLE    = 2'(REGISTER_IDLE_OPERATION);

    state_t      state, state_n;
    logic [31:0] length_q, length_n;
    logic [31:0] clear_count, clear_count_n;
    logic [7:0]  k, k_n;
    logic [31:0] elapsed_n;
    logic        timeout_n;
    logic [7:0]  register_number_n;
    logic [31:0] register_write_n;
    logic        length_hit;

    // elapsed counts completed enable cycles, so elapsed == L-1 marks the L-th cycle
    assign length_hit = (length_q != 32'd0) && (elapsed == length_q - 32'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= S_IDLE;
            length_q           <= 32'd0;
            clear_count        <= 32'd0;
            k                  <= 8'd0;
            analyzer_clear     <= 1'b0;
            analyzer_enable    <= 1'b0;
            value_index        <= 8'd0;
            register_operation <= 2'd0;
            register_number    <= 8'd0;
            register_write     <= 32'd0;
            busy               <= 1'b0;
            irq                <= 1'b0;
            timeout            <= 1'b0;
            elapsed            <= 32'd0;
        end else begin
            state              <= state_n;
            length_q           <= length_n;
            clear_count        <= clear_count_n;
            k                  <= k_n;
            analyzer_clear     <= (state_n == S_CLEAR);
            analyzer_enable    <= (state_n == S_MEASURE);
            value_index        <= (state_n == S_SELECT) ? k_n : 8'd0;
            register_operation <= (state_n == S_WRITE) ? OP_WRITE : OP_IDLE;
            register_number    <= register_number_n;
            register_write     <= register_write_n;
            busy               <= (state_n != S_IDLE);
            irq                <= (state_n == S_DONE);
            timeout            <= timeout_n;
            elapsed            <= elapsed_n;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        state_n           = state;
        length_n          = length_q;
        clear_count_n     = clear_count;
        k_n               = k;
        elapsed_n         = elapsed;
        timeout_n         = timeout;
        register_number_n = register_number;
        register_write_n  = register_write;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n       = S_CLEAR;
                    length_n      = window_length;
                    elapsed_n     = 32'd0;
                    clear_count_n = 32'd0;
                end
            end
            S_CLEAR: begin
                if (clear_count == CLEAR_LAST) begin
                    state_n = S_MEASURE;
                end else begin
                    clear_count_n = clear_count + 32'd1;
                end
            end
            S_MEASURE: begin
                if (elapsed != 32'hFFFF_FFFF) begin
                    elapsed_n = elapsed + 32'd1;
                end
                if (length_hit || stop) begin
                    state_n   = S_SELECT;
                    k_n       = 8'd1;
                    timeout_n = length_hit;
                end
            end
            S_SELECT: begin
                state_n           = S_WRITE;
                register_number_n = k;
                register_write_n  = value_data;
            end
            S_WRITE: begin
                if (k < LAST_K) begin
                    k_n     = k + 8'd1;
                    state_n = S_SELECT;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frequency_capture_sequencer.sv
// Randomized bench for frequency_capture_sequencer; a timeline model derives every
// output per cycle from the window length, stop time and readout schedule.
module tb_frequency_capture_sequencer;

    localparam int N  = 6;
    localparam int CC = 2;
    localparam int M0 = CC + 1;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] window_length;
    logic        analyzer_clear;
    logic        analyzer_enable;
    logic [7:0]  value_index;
    logic [31:0] value_data;
    logic [1:0]  register_operation;
    logic [7:0]  register_number;
    logic [31:0] register_write;
    logic        busy;
    logic        irq;
    logic        timeout;
    logic [31:0] elapsed;
    logic [31:0] data_base;

    int compared;
    int mismatched;
    int prev_elapsed;
    int prev_timeout;
    int last_num;
    logic [31:0] last_wr;

    frequency_capture_sequencer #(
        .NUM_VALUES(N),
        .CLEAR_CYCLES(CC),
        .REGISTER_WRITE_OPERATION(2),
        .REGISTER_IDLE_OPERATION(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .stop(stop),
        .window_length(window_length),
        .analyzer_clear(analyzer_clear),
        .analyzer_enable(analyzer_enable),
        .value_index(value_index),
        .value_data(value_data),
        .register_operation(register_operation),
        .register_number(register_number),
        .register_write(register_write),
        .busy(busy),
        .irq(irq),
        .timeout(timeout),
        .elapsed(elapsed)
    );

    // External result mux stand-in: each index maps to a distinct word
    assign value_data = data_base + {24'd0, value_index};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got 0x%08h, expected 0x%08h", tag, $time, observed, expected);
        end
    endtask

    task automatic compareAll(input int e_clr, input int e_en, input int e_busy, input int e_irq,
                              input int e_idx, input int e_op, input int e_el, input int e_to);
        checkOutput("analyzer_clear", 32'(analyzer_clear), 32'(e_clr));
        checkOutput("analyzer_enable", 32'(analyzer_enable), 32'(e_en));
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("irq", 32'(irq), 32'(e_irq));
        checkOutput("value_index", 32'(value_index), 32'(e_idx));
        checkOutput("register_operation", 32'(register_operation), 32'(e_op));
        checkOutput("register_number", 32'(register_number), 32'(last_num));
        checkOutput("register_write", register_write, last_wr);
        checkOutput("elapsed", elapsed, 32'(e_el));
        checkOutput("timeout", 32'(timeout), 32'(e_to));
    endtask

    task automatic modelReset();
        prev_elapsed = 0;
        prev_timeout = 0;
        last_num     = 0;
        last_wr      = 32'd0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            start         = 1'b0;
            stop          = 1'($urandom_range(0, 1));
            window_length = $urandom;
            @(negedge clock);
            compareAll(0, 0, 0, 0, 0, 0, prev_elapsed, prev_timeout);
            @(posedge clock);
            #1;
        end
    endtask

    // One run with start sampled at t=0; s<0 means no stop; abort_at>=0 pulses reset at that cycle
    task automatic applyStimulus(input int len, input int s, input bit noise, input int abort_at,
                                 input logic [31:0] base);
        int big, wl, ws, w, done_t, r;
        int e_clr, e_en, e_busy, e_irq, e_idx, e_op, e_el, e_to;
        bit new_to;
        big    = 1 << 30;
        wl     = (len != 0) ? len : big;
        ws     = (s >= M0) ? (s - M0 + 1) : big;
        w      = (wl < ws) ? wl : ws;
        new_to = (len != 0) && (wl <= ws);
        done_t = M0 + w + 2 * N;
        data_base = base;
        for (int t = 0; t <= done_t; t++) begin
            if (t == 0) begin
                start         = 1'b1;
                window_length = 32'(len);
            end else begin
                start = noise ? ((t >= done_t - 1) || ($urandom_range(0, 2) == 0)) : 1'b0;
                if (noise) window_length = $urandom;
            end
            if (t == s && s >= M0)
                stop = 1'b1;
            else if (noise && t >= 1 && (t < M0 || t >= M0 + w))
                stop = 1'($urandom_range(0, 1));
            else
                stop = 1'b0;
            reset = (t == abort_at);

            e_clr  = (t >= 1 && t <= CC) ? 1 : 0;
            e_en   = (t >= M0 && t < M0 + w) ? 1 : 0;
            e_busy = (t >= 1) ? 1 : 0;
            e_irq  = (t == done_t) ? 1 : 0;
            e_idx  = 0;
            e_op   = 0;
            r      = t - (M0 + w);
            if (r >= 0 && r < 2 * N) begin
                if (r % 2 == 0) begin
                    e_idx = r / 2 + 1;
                end else begin
                    e_op     = 2;
                    last_num = (r + 1) / 2;
                    last_wr  = base + 32'(last_num);
                end
            end
            if (t == 0)          e_el = prev_elapsed;
            else if (t < M0)     e_el = 0;
            else if (t < M0 + w) e_el = t - M0;
            else                 e_el = w;
            e_to = (t < M0 + w) ? prev_timeout : int'(new_to);

            @(negedge clock);
            compareAll(e_clr, e_en, e_busy, e_irq, e_idx, e_op, e_el, e_to);
            @(posedge clock);
            #1;
            if (t == abort_at) begin
                reset = 1'b0;
                start = 1'b0;
                stop  = 1'b0;
                modelReset();
                @(negedge clock);
                compareAll(0, 0, 0, 0, 0, 0, 0, 0);
                @(posedge clock);
                #1;
                return;
            end
        end
        prev_elapsed = w;
        prev_timeout = int'(new_to);
    endtask

    initial begin
        int len, s;
        compared   = 0;
        mismatched = 0;
        reset         = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        window_length = 32'd0;
        data_base     = 32'h100;
        modelReset();
        @(posedge clock);
        @(posedge clock);
        #1;
        @(negedge clock);
        compareAll(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        idleCycles(2);

        $display("[TB] length-terminated window");
        applyStimulus(10, -1, 1'b0, -1, 32'h100);
        idleCycles(3);
        $display("[TB] stop-terminated window");
        applyStimulus(1000, 7, 1'b0, -1, 32'h100);
        idleCycles(2);
        $display("[TB] unbounded window");
        applyStimulus(0, 50, 1'b0, -1, 32'h100);
        idleCycles(2);
        $display("[TB] control noise and back-to-back runs");
        applyStimulus(10, -1, 1'b1, -1, 32'h100);
        applyStimulus(10, -1, 1'b1, -1, 32'h200);
        idleCycles(2);
        $display("[TB] reset mid-readout");
        applyStimulus(10, -1, 1'b0, 18, 32'h100);
        idleCycles(4);
        applyStimulus(10, -1, 1'b0, -1, 32'h300);
        idleCycles(2);
        $display("[TB] stop coincides with length");
        applyStimulus(4, M0 + 3, 1'b0, -1, 32'h100);
        applyStimulus(1, M0, 1'b0, -1, 32'h400);
        idleCycles(2);

        $display("[TB] randomized runs");
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                len = 0;
                s   = M0 + int'($urandom_range(0, 25));
            end else begin
                len = int'($urandom_range(1, 25));
                s   = ($urandom_range(0, 1) == 1) ? M0 + int'($urandom_range(0, 30)) : -1;
            end
            applyStimulus(len, s, 1'($urandom_range(0, 1)), -1, $urandom);
            if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 3)));
        end
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
